ibis_wdata_fifo: RTL and testbench

Buffers 32-bit write-data beats accepted by the AXI4 slave front end (its `wdata`/`wvalid`/`wready` channel) and hands them in order to the downstream Ibis command consumer over a valid/ready interface. It decouples AXI write bursts from consumer stalls and gives the slave an `almost_full` hint so it can hold off `awready` before the buffer fills. The FIFO is show-ahead: the head word is presented without a read request.

---
 rtl/ibis_wdata_fifo_if.sv | 31 +++
 rtl/ibis_wdata_fifo.sv | 90 +++++++++
 tb/tb_ibis_wdata_fifo.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ibis_wdata_fifo_if.sv
// Handshake bundle between the AXI write-data front end, the Ibis write-data FIFO and its consumer.
// Latency: none; wires only.
// Backpressure: s_ready/m_valid, driven by the FIFO, gate every hand-off.
// Ports (signals): enable, flush, s_data/s_valid/s_ready (write side), m_data/m_valid/m_ready (read side),
//   level/almost_full/empty/full (status). Modport slave = the FIFO, modport master = its environment.
interface ibis_wdata_fifo_if #(
  parameter int DEPTH = 16
);
  logic                     enable;
  logic                     flush;
  logic [31:0]              s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic [31:0]              m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic [$clog2(DEPTH):0]   level;
  logic                     almost_full;
  logic                     empty;
  logic                     full;

  modport slave (
    input  enable, flush, s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, level, almost_full, empty, full
  );

  modport master (
    output enable, flush, s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, level, almost_full, empty, full
  );
endinterface

// File: rtl/ibis_wdata_fifo.sv
// Show-ahead FIFO buffering AXI write-data beats for the Ibis command consumer.
// Latency: a word pushed at edge N is on m_data with m_valid high in cycle N+1; one push and one pop per cycle.
// Backpressure: s_ready drops when full, disabled, flushing or just out of reset; no bypass either way.
// Ports: aclk, aresetn (async active-low); bus (slave modport) carries enable, flush, the s_* write side,
//   the m_* read side and the level/almost_full/empty/full status.
module ibis_wdata_fifo #(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 14
) (
  input  logic              aclk,
  input  logic              aresetn,
  ibis_wdata_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Set on the first edge after reset release; keeps both sides closed during that first cycle.
  logic              rdy_q;
  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [31:0]       mem [DEPTH];

  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic [PW-1:0]     level_w;
  logic              empty_w;
  logic              full_w;
  logic              open_w;
  logic              push;
  logic              pop;

  assign wr_idx  = wr_ptr[AW-1:0];
  assign rd_idx  = rd_ptr[AW-1:0];

  // Modulo-2*DEPTH subtraction falls out of the PW-bit wraparound.
  assign level_w = wr_ptr - rd_ptr;
  assign empty_w = (wr_ptr == rd_ptr);
  assign full_w  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

  // Status comes from the stored pointers only, so it stays truthful while frozen.
  // Handshakes look at the current pointers, never at this cycle's opposite hand-off: no bypass.
  assign open_w       = rdy_q & bus.enable & ~bus.flush;
  assign bus.s_ready  = open_w & ~full_w;
  assign bus.m_valid  = open_w & ~empty_w;
  assign push         = bus.s_valid & bus.s_ready;
  assign pop          = bus.m_valid & bus.m_ready;

  assign bus.level       = level_w;
  assign bus.empty       = empty_w;
  assign bus.full        = full_w;
  assign bus.almost_full = (level_w >= PW'(AFULL_LEVEL));
  assign bus.m_data      = mem[rd_idx];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  // Flush only acts while enabled: a frozen block holds its pointers whatever the other inputs do.
  // Flush beats push/pop, which are already suppressed through open_w.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.enable && bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Data array needs no reset: nothing reads it while m_valid is low, and flush leaves it untouched.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_idx] <= bus.s_data;
    end
  end

endmodule

// File: tb/tb_ibis_wdata_fifo.sv
module tb_ibis_wdata_fifo;

  localparam int DEPTH = 16;
  localparam int AFL   = 14;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  ibis_wdata_fifo_if #(.DEPTH(DEPTH)) bus ();

  ibis_wdata_fifo #(.DEPTH(DEPTH), .AFULL_LEVEL(AFL)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] q [$];
  logic        mrdy   = 1'b0;

  function automatic logic exp_sr();
    return mrdy && bus.enable && !bus.flush && (q.size() < DEPTH);
  endfunction

  function automatic logic exp_mv();
    return mrdy && bus.enable && !bus.flush && (q.size() > 0);
  endfunction

  // Called just after a falling edge: apply inputs and let combinational outputs settle.
  task automatic drive(input logic sv, input logic [31:0] sd, input logic mr,
                       input logic en, input logic fl);
    bus.s_valid = sv;
    bus.s_data  = sd;
    bus.m_ready = mr;
    bus.enable  = en;
    bus.flush   = fl;
    #1;
  endtask

  // Predict this cycle's hand-offs from the model, clock once, update the scoreboard queue.
  task automatic advance();
    logic        ph;
    logic        pp;
    logic [31:0] d;
    ph = exp_sr() && bus.s_valid;
    pp = exp_mv() && bus.m_ready;
    d  = bus.s_data;
    @(posedge aclk);
    if (!aresetn) begin
      q.delete();
      mrdy = 1'b0;
    end else begin
      if (bus.enable && bus.flush) begin
        q.delete();
      end else begin
        if (pp) void'(q.pop_front());
        if (ph) q.push_back(d);
      end
      mrdy = 1'b1;
    end
    @(negedge aclk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.s_ready !== 1'b0) $display("FAIL reset_s_ready cyc=%0d got=%b want=0", i, bus.s_ready); else passed++;
      total++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid cyc=%0d got=%b want=0", i, bus.m_valid); else passed++;
      total++; if (bus.empty !== 1'b1) $display("FAIL reset_empty cyc=%0d got=%b want=1", i, bus.empty); else passed++;
      total++; if (bus.level !== LW'(0)) $display("FAIL reset_level cyc=%0d got=%0d want=0", i, bus.level); else passed++;
      total++; if ({bus.full, bus.almost_full} !== 2'b00) $display("FAIL reset_flags cyc=%0d got=%b want=00", i, {bus.full, bus.almost_full}); else passed++;
      advance();
    end
    aresetn = 1'b1;
    #1;
    total++; if (bus.s_ready !== 1'b0) $display("FAIL release_s_ready got=%b want=0", bus.s_ready); else passed++;
    total++; if (bus.m_valid !== 1'b0) $display("FAIL release_m_valid got=%b want=0", bus.m_valid); else passed++;
    total++; if (bus.empty !== 1'b1) $display("FAIL release_empty got=%b want=1", bus.empty); else passed++;
    advance();
    total++; if (bus.s_ready !== 1'b1) $display("FAIL second_cycle_s_ready got=%b want=1", bus.s_ready); else passed++;
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h1000_0000 + i, 1'b0, 1'b1, 1'b0);
      total++; if (bus.s_ready !== 1'b1) $display("FAIL fill_s_ready i=%0d got=%b want=1", i, bus.s_ready); else passed++;
      advance();
      total++; if (bus.level !== LW'(i + 1)) $display("FAIL fill_level i=%0d got=%0d want=%0d", i, bus.level, i + 1); else passed++;
      total++; if (bus.almost_full !== ((i + 1) >= AFL)) $display("FAIL fill_afull i=%0d got=%b want=%b", i, bus.almost_full, ((i + 1) >= AFL)); else passed++;
      total++; if (bus.full !== ((i + 1) == DEPTH)) $display("FAIL fill_full i=%0d got=%b want=%b", i, bus.full, ((i + 1) == DEPTH)); else passed++;
    end
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    total++; if (bus.s_ready !== 1'b0) $display("FAIL full_s_ready got=%b want=0", bus.s_ready); else passed++;
    advance();
    total++; if (bus.level !== LW'(DEPTH)) $display("FAIL extra_push_level got=%0d want=%0d", bus.level, DEPTH); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      exp = (q.size() > 0) ? q[0] : 32'hFFFF_FFFF;
      total++; if (bus.m_valid !== 1'b1) $display("FAIL drain_m_valid i=%0d got=%b want=1", i, bus.m_valid); else passed++;
      total++; if (bus.m_data !== exp || exp !== 32'h1000_0000 + i) $display("FAIL drain_data i=%0d got=%h want=%h", i, bus.m_data, 32'h1000_0000 + i); else passed++;
      advance();
    end
    total++; if (bus.empty !== 1'b1) $display("FAIL drain_empty got=%b want=1", bus.empty); else passed++;
  endtask

  task automatic test_streaming();
    int outs = 0;
    for (int k = 0; k <= 100; k++) begin
      drive(k < 100, 32'h2000_0000 + k, 1'b1, 1'b1, 1'b0);
      if (k == 0) begin
        total++; if (bus.m_valid !== 1'b0) $display("FAIL stream_no_bypass got=%b want=0", bus.m_valid); else passed++;
      end else begin
        total++; if (bus.level !== LW'(1)) $display("FAIL stream_level k=%0d got=%0d want=1", k, bus.level); else passed++;
        total++; if (bus.m_valid !== 1'b1) $display("FAIL stream_m_valid k=%0d got=%b want=1", k, bus.m_valid); else passed++;
        if (q.size() > 0) begin
          total++; if (bus.m_data !== q[0]) $display("FAIL stream_data k=%0d got=%h want=%h", k, bus.m_data, q[0]); else passed++;
          outs++;
        end
      end
      if (k < 100) begin
        total++; if (bus.s_ready !== 1'b1) $display("FAIL stream_s_ready k=%0d got=%b want=1", k, bus.s_ready); else passed++;
      end
      advance();
    end
    total++; if (outs !== 100 || bus.empty !== 1'b1) $display("FAIL stream_count got=%0d empty=%b want=100 empty=1", outs, bus.empty); else passed++;
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h3000_0000 + i, 1'b0, 1'b1, 1'b0);
      advance();
    end
    drive(1'b1, 32'h3000_00AA, 1'b1, 1'b1, 1'b0);
    total++; if (bus.s_ready !== 1'b0) $display("FAIL fullpop_s_ready got=%b want=0", bus.s_ready); else passed++;
    total++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h3000_0000) $display("FAIL fullpop_head got=%b/%h want=1/30000000", bus.m_valid, bus.m_data); else passed++;
    advance();
    total++; if (bus.level !== LW'(15)) $display("FAIL fullpop_level got=%0d want=15", bus.level); else passed++;
    drive(1'b1, 32'h3000_00AA, 1'b0, 1'b1, 1'b0);
    total++; if (bus.s_ready !== 1'b1) $display("FAIL refill_s_ready got=%b want=1", bus.s_ready); else passed++;
    advance();
    total++; if (bus.level !== LW'(16)) $display("FAIL refill_level got=%0d want=16", bus.level); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      total++; if (q.size() == 0 || bus.m_valid !== 1'b1 || bus.m_data !== q[0]) $display("FAIL fullpop_drain i=%0d got=%b/%h", i, bus.m_valid, bus.m_data); else passed++;
      advance();
    end
    total++; if (bus.empty !== 1'b1) $display("FAIL fullpop_empty got=%b want=1", bus.empty); else passed++;
  endtask

  task automatic test_flush_enable();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h4000_0000 + i, 1'b0, 1'b1, 1'b0);
      advance();
    end
    drive(1'b1, 32'h4000_00FF, 1'b1, 1'b1, 1'b1);
    total++; if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0) $display("FAIL flush_hs got=%b%b want=00", bus.s_ready, bus.m_valid); else passed++;
    advance();
    total++; if (bus.level !== LW'(0) || bus.empty !== 1'b1) $display("FAIL flush_level got=%0d empty=%b want=0 empty=1", bus.level, bus.empty); else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h5000_0000 + i, 1'b0, 1'b1, 1'b0);
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), 1'b0, 1'b0);
      total++; if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0) $display("FAIL disabled_hs i=%0d got=%b%b want=00", i, bus.s_ready, bus.m_valid); else passed++;
      total++; if (bus.level !== LW'(3)) $display("FAIL disabled_level i=%0d got=%0d want=3", i, bus.level); else passed++;
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      total++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h5000_0000 + i) $display("FAIL reenable_data i=%0d got=%b/%h want=1/%h", i, bus.m_valid, bus.m_data, 32'h5000_0000 + i); else passed++;
      advance();
    end
    total++; if (bus.empty !== 1'b1) $display("FAIL reenable_empty got=%b want=1", bus.empty); else passed++;
  endtask

  task automatic test_stress();
    logic sv;
    logic mr;
    logic fl;
    for (int c = 0; c < 10000; c++) begin
      sv = ($urandom_range(9) < 7);
      mr = ($urandom_range(9) < 6);
      fl = ($urandom_range(99) == 0);
      aresetn = (c == 5000) ? 1'b0 : 1'b1;
      if (c == 5000) begin
        q.delete();
        mrdy = 1'b0;
      end
      drive(sv, $urandom, mr, 1'b1, fl);
      total++; if (bus.s_ready !== exp_sr()) $display("FAIL stress_s_ready c=%0d got=%b want=%b", c, bus.s_ready, exp_sr()); else passed++;
      total++; if (bus.m_valid !== exp_mv()) $display("FAIL stress_m_valid c=%0d got=%b want=%b", c, bus.m_valid, exp_mv()); else passed++;
      total++; if (bus.level !== LW'(q.size())) $display("FAIL stress_level c=%0d got=%0d want=%0d", c, bus.level, q.size()); else passed++;
      if (exp_mv() && mr) begin
        total++; if (bus.m_data !== q[0]) $display("FAIL stress_data c=%0d got=%h want=%h", c, bus.m_data, q[0]); else passed++;
      end
      advance();
    end
    aresetn = 1'b1;
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge aclk);
    test_reset();
    test_fill_drain();
    test_streaming();
    test_full_pop();
    test_flush_enable();
    test_stress();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
